// File: rtl/latch_edge_monitor.sv
// Synchronises a D-latch (q, q') pair, tracks its level and counts accepted edges.
// Optional LATCH_MON_GLITCH_FILTER_EN: a level change must persist 3 synced cycles.
module latch_edge_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int ERR_CYCLES  = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             q_in,
  input  logic             q_comp_in,
  input  logic             clr_in,
  output logic             level_out,
  output logic             rise_out,
  output logic             fall_out,
  output logic [CNT_W-1:0] rise_cnt_out,
  output logic [CNT_W-1:0] fall_cnt_out,
  output logic             sat_out,
  output logic             fault_out
);

  typedef enum logic [1:0] {
    ST_UNKNOWN = 2'd0,
    ST_LOW     = 2'd1,
    ST_HIGH    = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  localparam int                WARM_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES);
  localparam logic [3:0]        ERR_LIM   = 4'(ERR_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] r_q_sync, r_qc_sync;
  state_t                 r_state, w_state_nxt;
  logic [WARM_W-1:0]      r_warm, w_warm_nxt;
  logic [3:0]             r_mis, w_mis_nxt;
  logic [CNT_W-1:0]       r_rise_cnt, r_fall_cnt;
  logic [CNT_W-1:0]       w_rise_base, w_fall_base, w_rise_cnt_nxt, w_fall_cnt_nxt;
  logic                   r_level, r_rise, r_fall, r_sat, r_fault;
  logic                   w_qs, w_valid, w_opp, w_accept, w_rise, w_fall;
`ifdef LATCH_MON_GLITCH_FILTER_EN
  logic [1:0]             r_pend, w_pend_nxt;
`endif

  assign w_qs    = r_q_sync[SYNC_STAGES-1];
  assign w_valid = r_q_sync[SYNC_STAGES-1] ^ r_qc_sync[SYNC_STAGES-1];
  // A valid pair at the level opposite to the one currently tracked.
  assign w_opp   = ((r_state == ST_LOW) & w_qs) | ((r_state == ST_HIGH) & ~w_qs);
`ifdef LATCH_MON_GLITCH_FILTER_EN
  assign w_accept = w_opp & (r_pend == 2'd2);
`else
  assign w_accept = w_opp;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_q_sync  <= '0;
      r_qc_sync <= '0;
    end else begin
      r_q_sync  <= {r_q_sync[SYNC_STAGES-2:0], q_in};
      r_qc_sync <= {r_qc_sync[SYNC_STAGES-2:0], q_comp_in};
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ST_UNKNOWN;
      r_warm  <= '0;
      r_mis   <= 4'd0;
`ifdef LATCH_MON_GLITCH_FILTER_EN
      r_pend  <= 2'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_warm  <= w_warm_nxt;
      r_mis   <= w_mis_nxt;
`ifdef LATCH_MON_GLITCH_FILTER_EN
      r_pend  <= w_pend_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_warm_nxt  = r_warm;
    w_mis_nxt   = r_mis;
    w_rise      = 1'b0;
    w_fall      = 1'b0;
`ifdef LATCH_MON_GLITCH_FILTER_EN
    w_pend_nxt  = r_pend;
`endif
    if (r_warm != WARM_DONE) begin
      // Synchroniser still holds reset zeros; the pair is meaningless.
      w_warm_nxt = r_warm + WARM_W'(1);
    end else if (!w_valid) begin
`ifdef LATCH_MON_GLITCH_FILTER_EN
      w_pend_nxt = 2'd0;
`endif
      if (r_state != ST_FAULT) begin
        w_mis_nxt = r_mis + 4'd1;
        if (w_mis_nxt >= ERR_LIM) begin
          w_state_nxt = ST_FAULT;
        end else begin
          w_state_nxt = r_state;
        end
      end else begin
        w_mis_nxt = r_mis;
      end
    end else begin
      w_mis_nxt = 4'd0;
      case (r_state)
        ST_LOW, ST_HIGH: begin
          if (w_accept) begin
            w_state_nxt = w_qs ? ST_HIGH : ST_LOW;
            w_rise      = w_qs;
            w_fall      = ~w_qs;
          end else begin
            w_state_nxt = r_state;
          end
`ifdef LATCH_MON_GLITCH_FILTER_EN
          w_pend_nxt = (w_accept || !w_opp) ? 2'd0 : r_pend + 2'd1;
`endif
        end
        default: begin
          w_state_nxt = w_qs ? ST_HIGH : ST_LOW;
`ifdef LATCH_MON_GLITCH_FILTER_EN
          w_pend_nxt  = 2'd0;
`endif
        end
      endcase
    end
  end

  // Clear applies first so an edge in the same cycle lands on a zeroed counter.
  always_comb begin
    w_rise_base    = clr_in ? '0 : r_rise_cnt;
    w_fall_base    = clr_in ? '0 : r_fall_cnt;
    w_rise_cnt_nxt = (w_rise && (w_rise_base != CNT_MAX)) ? w_rise_base + CNT_W'(1) : w_rise_base;
    w_fall_cnt_nxt = (w_fall && (w_fall_base != CNT_MAX)) ? w_fall_base + CNT_W'(1) : w_fall_base;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rise_cnt <= '0;
      r_fall_cnt <= '0;
      r_sat      <= 1'b0;
      r_level    <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_rise_cnt <= w_rise_cnt_nxt;
      r_fall_cnt <= w_fall_cnt_nxt;
      r_sat      <= (clr_in ? 1'b0 : r_sat) | (w_rise_cnt_nxt == CNT_MAX) | (w_fall_cnt_nxt == CNT_MAX);
      r_level    <= (w_state_nxt == ST_HIGH);
      r_rise     <= w_rise;
      r_fall     <= w_fall;
      r_fault    <= (w_state_nxt == ST_FAULT);
    end
  end

  assign level_out    = r_level;
  assign rise_out     = r_rise;
  assign fall_out     = r_fall;
  assign rise_cnt_out = r_rise_cnt;
  assign fall_cnt_out = r_fall_cnt;
  assign sat_out      = r_sat;
  assign fault_out    = r_fault;

endmodule

// File: tb/tb_latch_edge_monitor.sv
// Randomised and directed bench for latch_edge_monitor against a queue-based reference model.
module tb_latch_edge_monitor;
  localparam int SS    = 2;
  localparam int CW    = 3;
  localparam int EC    = 2;
`ifdef LATCH_MON_GLITCH_FILTER_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 1;
`endif
  localparam int MAXC  = (1 << CW) - 1;
  localparam int VW    = 5 + 2 * CW;
  localparam int M_UNK = 0, M_LO = 1, M_HI = 2, M_FLT = 3;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          q_in = 1'b0, q_comp_in = 1'b1, clr_in = 1'b0;
  logic          level_out, rise_out, fall_out, sat_out, fault_out;
  logic [CW-1:0] rise_cnt_out, fall_cnt_out;

  int n_cmp = 0;
  int n_mis = 0;

  bit mh_q[$], mh_qc[$];
  int m_warm, m_state, m_mis, m_pend, m_rc, m_fc;
  bit m_sat, m_rise, m_fall;

  always #5 clk_in = ~clk_in;

  latch_edge_monitor #(.SYNC_STAGES(SS), .CNT_W(CW), .ERR_CYCLES(EC)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .q_in(q_in), .q_comp_in(q_comp_in), .clr_in(clr_in),
    .level_out(level_out), .rise_out(rise_out), .fall_out(fall_out),
    .rise_cnt_out(rise_cnt_out), .fall_cnt_out(fall_cnt_out),
    .sat_out(sat_out), .fault_out(fault_out)
  );

  // Reference: the pair seen by the monitor is the input from SS edges ago.
  task automatic model_step(input bit q, input bit qc, input bit clr, input bit rst);
    bit pq, pqc;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (rst) begin
      mh_q.delete();
      mh_qc.delete();
      for (int i = 0; i < SS; i++) begin
        mh_q.push_back(1'b0);
        mh_qc.push_back(1'b0);
      end
      m_warm = 0; m_state = M_UNK; m_mis = 0; m_pend = 0;
      m_rc = 0; m_fc = 0; m_sat = 1'b0;
      return;
    end
    pq  = mh_q.pop_front();
    pqc = mh_qc.pop_front();
    mh_q.push_back(q);
    mh_qc.push_back(qc);
    if (m_warm < SS) begin
      m_warm++;
    end else if (pq == pqc) begin
      m_pend = 0;
      if (m_state != M_FLT) begin
        m_mis++;
        if (m_mis >= EC) m_state = M_FLT;
      end
    end else begin
      m_mis = 0;
      if (m_state == M_UNK || m_state == M_FLT) begin
        m_state = pq ? M_HI : M_LO;
        m_pend  = 0;
      end else if ((m_state == M_HI) != pq) begin
        m_pend++;
        if (m_pend == DEPTH) begin
          m_pend  = 0;
          m_rise  = pq;
          m_fall  = !pq;
          m_state = pq ? M_HI : M_LO;
        end
      end else begin
        m_pend = 0;
      end
    end
    if (clr) begin
      m_rc = 0; m_fc = 0; m_sat = 1'b0;
    end
    if (m_rise && m_rc < MAXC) m_rc++;
    if (m_fall && m_fc < MAXC) m_fc++;
    if (m_rc == MAXC || m_fc == MAXC) m_sat = 1'b1;
  endtask

  task automatic cyc(input bit q, input bit qc, input bit clr, input bit rst);
    @(negedge clk_in);
    q_in = q; q_comp_in = qc; clr_in = clr; rst_in = rst;
    @(posedge clk_in);
    model_step(q, qc, clr, rst);
    #1;
  endtask

  function automatic logic [VW-1:0] got_vec();
    return {level_out, rise_out, fall_out, rise_cnt_out, fall_cnt_out, sat_out, fault_out};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_state == M_HI, m_rise, m_fall, CW'(m_rc), CW'(m_fc), m_sat, m_state == M_FLT};
  endfunction

  task automatic test_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (got_vec() !== '0) begin
      n_mis++;
      $display("FAIL reset_outputs: got %h required %h", got_vec(), {VW{1'b0}});
    end
    for (int i = 0; i < SS + 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_mis++;
        $display("FAIL warmup[%0d]: got %h required %h", i, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_edges();
    int rise_at = -1;
    for (int i = 0; i < SS + DEPTH + 2; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      if (rise_out === 1'b1 && rise_at < 0) rise_at = i;
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_mis++;
        $display("FAIL rise_seq[%0d]: got %h required %h", i, got_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (rise_at != SS + DEPTH - 1 || rise_cnt_out !== 3'd1) begin
      n_mis++;
      $display("FAIL rise_latency: pulse at %0d cnt %0d required %0d cnt 1", rise_at, rise_cnt_out, SS + DEPTH - 1);
    end
    for (int i = 0; i < SS + DEPTH + 2; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_mis++;
        $display("FAIL fall_seq[%0d]: got %h required %h", i, got_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (fall_cnt_out !== 3'd1 || level_out !== 1'b0) begin
      n_mis++;
      $display("FAIL fall_count: cnt %0d level %b required cnt 1 level 0", fall_cnt_out, level_out);
    end
  endtask

  task automatic test_skew_fault();
    bit saw_fault = 1'b0;
    bit saw_rise  = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < SS + 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      if (fault_out === 1'b1) saw_fault = 1'b1;
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_mis++;
        $display("FAIL skew_tolerated[%0d]: got %h required %h", i, got_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (saw_fault !== 1'b0) begin
      n_mis++;
      $display("FAIL skew_no_fault: fault seen %b required 0", saw_fault);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < SS + 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      if (fault_out === 1'b1) saw_fault = 1'b1;
      if (rise_out === 1'b1) saw_rise = 1'b1;
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_mis++;
        $display("FAIL fault_recover[%0d]: got %h required %h", i, got_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (saw_fault !== 1'b1 || saw_rise !== 1'b0 || level_out !== 1'b1 || rise_cnt_out !== 3'd1) begin
      n_mis++;
      $display("FAIL fault_exit: fault %b rise %b level %b cnt %0d required 1 0 1 1",
               saw_fault, saw_rise, level_out, rise_cnt_out);
    end
  endtask

  task automatic test_saturation();
    for (int t = 0; t < 9; t++) begin
      for (int i = 0; i < 2 * (SS + DEPTH + 1); i++) begin
        if (i < SS + DEPTH + 1) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        else                    cyc(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (got_vec() !== exp_vec()) begin
          n_mis++;
          $display("FAIL sat_toggle[%0d.%0d]: got %h required %h", t, i, got_vec(), exp_vec());
        end
      end
    end
    n_cmp++;
    if (rise_cnt_out !== 3'd7 || fall_cnt_out !== 3'd7 || sat_out !== 1'b1) begin
      n_mis++;
      $display("FAIL sat_hold: rise %0d fall %0d sat %b required 7 7 1", rise_cnt_out, fall_cnt_out, sat_out);
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (rise_cnt_out !== 3'd0 || fall_cnt_out !== 3'd0 || sat_out !== 1'b0) begin
      n_mis++;
      $display("FAIL clr: rise %0d fall %0d sat %b required 0 0 0", rise_cnt_out, fall_cnt_out, sat_out);
    end
  endtask

  task automatic test_clr_with_edge();
    for (int i = 0; i < SS + DEPTH + 2; i++) begin
      cyc(1'b1, 1'b0, (i == SS + DEPTH - 1), 1'b0);
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_mis++;
        $display("FAIL clr_edge_seq[%0d]: got %h required %h", i, got_vec(), exp_vec());
      end
      if (i == SS + DEPTH - 1) begin
        n_cmp++;
        if (rise_out !== 1'b1 || rise_cnt_out !== 3'd1) begin
          n_mis++;
          $display("FAIL clr_edge_wins: rise %b cnt %0d required 1 1", rise_out, rise_cnt_out);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int rises;
    for (int len = 2; len <= 3; len++) begin
      rises = 0;
      for (int i = 0; i < SS + DEPTH + 1; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < len + SS + 4; i++) begin
        if (i < len) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        else         cyc(1'b0, 1'b1, 1'b0, 1'b0);
        if (rise_out === 1'b1) rises++;
        n_cmp++;
        if (got_vec() !== exp_vec()) begin
          n_mis++;
          $display("FAIL glitch%0d[%0d]: got %h required %h", len, i, got_vec(), exp_vec());
        end
      end
      n_cmp++;
      if (rises != ((len >= DEPTH) ? 1 : 0)) begin
        n_mis++;
        $display("FAIL glitch%0d_pulses: got %0d required %0d", len, rises, (len >= DEPTH) ? 1 : 0);
      end
    end
  endtask

  task automatic test_random();
    bit lvl = 1'b0;
    bit q, qc, clr, rst;
    int r;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10) lvl = ~lvl;
      q  = lvl;
      qc = ~lvl;
      if (r >= 10 && r < 16) begin
        q  = $urandom_range(0, 1);
        qc = q;
      end
      clr = ($urandom_range(0, 99) < 4);
      rst = ($urandom_range(0, 199) < 2);
      cyc(q, qc, clr, rst);
      n_cmp++;
      if (got_vec() !== exp_vec()) begin
        n_mis++;
        $display("FAIL random[%0d]: got %h required %h", i, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_edges();
    test_skew_fault();
    test_saturation();
    test_clr_with_edge();
    test_glitch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
